snake_row_scheduler: RTL and testbench
======================================

Name: snake_row_scheduler

Overview:
- Per-tile-row occupancy scheduler for the snake render path.
- On each row request, it walks the snake segment list held in a segment RAM (entry 0 is the head; a coordinate of -1 marks an absent part).
- It builds a GRID_W-bit column mask for the requested tile row and publishes it as a registered result.
- The VGA pixel path reads row_mask/head_col instead of comparing every segment against every pixel.

Parameters:
- GRID_W, 10, tile columns on the board.
- GRID_H, 10, tile rows on the board.
- MAX_SEGS, 100, segment RAM depth and hard cap on entries walked.
- COORD_W, 32, width of each stored x/y coordinate; all-ones (-1) means absent.
- ADDR_W, 7, segment RAM address width; must satisfy 2^ADDR_W >= MAX_SEGS.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- frame_start  in  1  one-cycle pulse between frames (screenEnd); aborts any scan and clears results.
- row_req  in  1  one-cycle pulse requesting a scan.
- row_idx  in  COORD_W  tile row to scan; sampled with row_req.
- seg_count  in  ADDR_W+1  live segment count; sampled with row_req.
- seg_rd  out  1  segment RAM read strobe.
- seg_addr  out  ADDR_W  segment RAM address.
- seg_x  in  COORD_W  RAM x data; valid exactly 1 cycle after the seg_rd cycle.
- seg_y  in  COORD_W  RAM y data; same timing as seg_x.
- busy  out  1  high from the cycle after an accepted row_req until the mask_valid cycle inclusive.
- row_mask  out  GRID_W  bit c set = tile (c, row) occupied; held until the next publish or clear.
- head_hit  out  1  head segment lies in the published row.
- head_col  out  $clog2(GRID_W)  head column; meaningful only when head_hit = 1.
- mask_valid  out  1  one-cycle pulse on the cycle row_mask/head_* update.
- overrun  out  1  sticky: row_req arrived while busy.

Behaviour:
- Reset values (async, while reset = 0): all outputs 0, state IDLE, working mask 0.
- States and transitions:
  - IDLE: on row_req, latch row_idx and N = min(seg_count, MAX_SEGS), clear the working mask and head flags, go to SCAN (or DRAIN if N = 0).
  - SCAN: drive seg_rd = 1 with seg_addr = i for i = 0..N-1, one address per cycle. After issuing N-1, go to DRAIN.
  - DRAIN: wait for the last read data, then go to PUBLISH.
  - PUBLISH: copy the working mask to the output registers, assert mask_valid for 1 cycle, return to IDLE.
- Compare pipeline: a registered valid/index tag follows each read by 1 cycle. When a tagged entry returns:
  - Terminator: if seg_x == -1 or seg_y == -1, the entry sets nothing. It ends the walk: scanning stops, at most one already-issued read is discarded, and the block goes to PUBLISH on the next cycle.
  - Hit: else if seg_y == row_idx and seg_x < GRID_W (unsigned), set mask bit seg_x.
  - Head: if the hit entry has index 0, also set head_hit = 1 and head_col = seg_x.
  - Out-of-range coordinates are silently ignored.
  - Duplicate coordinates OR together.
- Latency: row_req in cycle 0 → mask_valid in cycle E + 2, where E = number of entries examined (E = N if no terminator; t+1 if the terminator is at index t; E = 0 gives cycle 2).
- row_req while busy: ignored (the running scan is unaffected) and overrun set to 1.
- row_req in the PUBLISH cycle also counts as busy.
- frame_start:
  - Any state → IDLE.
  - row_mask, head_hit, head_col and overrun cleared; mask_valid forced 0 that cycle; seg_rd forced 0 that cycle.
  - row_req coincident with frame_start: the clear is applied first, then the request is accepted (busy high the next cycle).
- row_idx >= GRID_H: a scan still runs and publishes an all-zero mask.
- Reset asserted mid-scan: immediate return to reset values; no mask_valid is issued.

Decomposition:
- Shared package snake_vga_pkg holds:
  - constants GRID_W, GRID_H, MAX_SEGS, COORD_ABSENT (all-ones), TILE_SIZE (40), BOARD_X0/BOARD_Y0 (48);
  - the FSM state encoding.
- One sub-module, snake_seg_match: registered compare stage taking seg_x, seg_y, tag and row_idx, returning hit, column, is_head and is_term. The FSM and address counter stay in the top.

Test Plan:
- Segments (3,2), (4,2), (4,3); seg_count = 3; row_req with row_idx = 2 → mask_valid in cycle 5, row_mask = 10'b0000011000, head_hit = 1, head_col = 3.
- Same RAM, row_idx = 3 → row_mask = 10'b0000010000, head_hit = 0.
- seg_count = 5 with entry 2 = (-1,-1) → seg_addr sequence 0,1,2(,3 discarded); mask_valid in cycle 5; only entries 0–1 counted.
- seg_count = 0 → mask_valid in cycle 2, row_mask = 0, no seg_rd asserted.
- row_req again 2 cycles into a 10-entry scan → first scan completes unchanged in cycle 12, overrun = 1. Then a frame_start pulse → overrun = 0 and row_mask = 0.
- reset driven low during SCAN, then released → all outputs 0, no mask_valid. A following row_req with seg_count = 1, entry (9,0), row_idx = 0 → row_mask = 10'b1000000000.

Source files
------------

// File: rtl/snake_vga_pkg.sv
// rtl/snake_vga_pkg.sv - shared board geometry constants and row scheduler state encoding
package snake_vga_pkg;

    localparam int GRID_W    = 10;
    localparam int GRID_H    = 10;
    localparam int MAX_SEGS  = 100;
    localparam int COORD_W   = 32;
    localparam int ADDR_W    = 7;
    localparam int COL_W     = $clog2(GRID_W);
    localparam int TILE_SIZE = 40;
    localparam int BOARD_X0  = 48;
    localparam int BOARD_Y0  = 48;

    localparam logic [COORD_W-1:0] COORD_ABSENT = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_PUBLISH
    } state_e;

endpackage

// File: rtl/snake_seg_match.sv
// rtl/snake_seg_match.sv - read tag register and segment-versus-row compare stage
module snake_seg_match
    import snake_vga_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd,
    input  logic [ADDR_W-1:0]  rd_idx,
    input  logic [COORD_W-1:0] seg_x,
    input  logic [COORD_W-1:0] seg_y,
    input  logic [COORD_W-1:0] row_idx,
    output logic               valid,
    output logic               hit,
    output logic [COL_W-1:0]   col,
    output logic               is_head,
    output logic               is_term
);

    logic              tag_vld_q, tag_vld_d;
    logic [ADDR_W-1:0] tag_idx_q, tag_idx_d;

    // The tag lines up with RAM data, which returns one cycle after the read strobe.
    always_comb begin
        tag_vld_d = rd;
        tag_idx_d = rd ? rd_idx : tag_idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= 1'b0;
            tag_idx_q <= '0;
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_idx_q <= tag_idx_d;
        end
    end

    always_comb begin
        valid   = tag_vld_q;
        is_term = tag_vld_q && ((seg_x == COORD_ABSENT) || (seg_y == COORD_ABSENT));
        // Rows beyond the board never match, so such a scan publishes an empty mask.
        hit     = tag_vld_q && !is_term && (seg_y == row_idx)
                  && (row_idx < COORD_W'(GRID_H)) && (seg_x < COORD_W'(GRID_W));
        col     = seg_x[COL_W-1:0];
        is_head = hit && (tag_idx_q == '0);
    end

endmodule

// File: rtl/snake_row_scheduler.sv
// rtl/snake_row_scheduler.sv - walks the segment RAM and publishes one tile row occupancy mask
module snake_row_scheduler
    import snake_vga_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               row_req,
    input  logic [COORD_W-1:0] row_idx,
    input  logic [ADDR_W:0]    seg_count,
    output logic               seg_rd,
    output logic [ADDR_W-1:0]  seg_addr,
    input  logic [COORD_W-1:0] seg_x,
    input  logic [COORD_W-1:0] seg_y,
    output logic               busy,
    output logic [GRID_W-1:0]  row_mask,
    output logic               head_hit,
    output logic [COL_W-1:0]   head_col,
    output logic               mask_valid,
    output logic               overrun
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic [COORD_W-1:0]  row_q, row_d;
    logic [GRID_W-1:0]   work_q, work_d;
    logic                whh_q, whh_d;
    logic [COL_W-1:0]    whc_q, whc_d;
    logic [GRID_W-1:0]   row_mask_q, row_mask_d;
    logic                head_hit_q, head_hit_d;
    logic [COL_W-1:0]    head_col_q, head_col_d;
    logic                overrun_q, overrun_d;

    logic                m_valid, m_hit, m_head, m_term;
    logic [COL_W-1:0]    m_col;
    logic [GRID_W-1:0]   merged_mask;
    logic                merged_hh;
    logic [COL_W-1:0]    merged_hc;
    logic                accept, publish;
    logic [ADDR_W:0]     n_req;

    snake_seg_match u_match (
        .clk     (clk),
        .rst_n   (reset),
        .rd      (seg_rd),
        .rd_idx  (idx_q),
        .seg_x   (seg_x),
        .seg_y   (seg_y),
        .row_idx (row_q),
        .valid   (m_valid),
        .hit     (m_hit),
        .col     (m_col),
        .is_head (m_head),
        .is_term (m_term)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        n_d        = n_q;
        row_d      = row_q;
        work_d     = work_q;
        whh_d      = whh_q;
        whc_d      = whc_q;
        row_mask_d = row_mask_q;
        head_hit_d = head_hit_q;
        head_col_d = head_col_q;
        overrun_d  = overrun_q;
        seg_rd     = 1'b0;
        accept     = 1'b0;
        publish    = 1'b0;
        n_req      = (seg_count > (ADDR_W+1)'(MAX_SEGS)) ? (ADDR_W+1)'(MAX_SEGS) : seg_count;

        // Working mask including the entry returning this cycle, so the last hit can be published directly.
        merged_mask = work_q;
        merged_hh   = whh_q;
        merged_hc   = whc_q;
        if (m_hit) begin
            merged_mask = work_q | (GRID_W'(1) << m_col);
            if (m_head) begin
                merged_hh = 1'b1;
                merged_hc = m_col;
            end
        end

        if (frame_start) begin
            state_d    = ST_IDLE;
            row_mask_d = '0;
            head_hit_d = 1'b0;
            head_col_d = '0;
            overrun_d  = 1'b0;
            accept     = row_req;
        end else begin
            case (state_q)
                ST_IDLE: accept = row_req;
                ST_SCAN: begin
                    seg_rd = 1'b1;
                    work_d = merged_mask;
                    whh_d  = merged_hh;
                    whc_d  = merged_hc;
                    // A terminator ends the walk; the read issued this cycle is dropped.
                    if (m_valid && m_term) begin
                        state_d = ST_PUBLISH;
                        publish = 1'b1;
                    end else if ({1'b0, idx_q} == (n_q - {{ADDR_W{1'b0}}, 1'b1})) begin
                        state_d = ST_DRAIN;
                    end else begin
                        idx_d = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DRAIN: begin
                    work_d  = merged_mask;
                    whh_d   = merged_hh;
                    whc_d   = merged_hc;
                    state_d = ST_PUBLISH;
                    publish = 1'b1;
                end
                ST_PUBLISH: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
            if (row_req && (state_q != ST_IDLE)) begin
                overrun_d = 1'b1;
            end
        end

        if (publish) begin
            row_mask_d = merged_mask;
            head_hit_d = merged_hh;
            head_col_d = merged_hc;
        end

        if (accept) begin
            row_d   = row_idx;
            n_d     = n_req;
            work_d  = '0;
            whh_d   = 1'b0;
            whc_d   = '0;
            idx_d   = '0;
            state_d = (n_req == '0) ? ST_DRAIN : ST_SCAN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            n_q        <= '0;
            row_q      <= '0;
            work_q     <= '0;
            whh_q      <= 1'b0;
            whc_q      <= '0;
            row_mask_q <= '0;
            head_hit_q <= 1'b0;
            head_col_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            n_q        <= n_d;
            row_q      <= row_d;
            work_q     <= work_d;
            whh_q      <= whh_d;
            whc_q      <= whc_d;
            row_mask_q <= row_mask_d;
            head_hit_q <= head_hit_d;
            head_col_q <= head_col_d;
            overrun_q  <= overrun_d;
        end
    end

    assign seg_addr   = idx_q;
    assign busy       = (state_q != ST_IDLE);
    assign mask_valid = (state_q == ST_PUBLISH) && !frame_start;
    assign row_mask   = row_mask_q;
    assign head_hit   = head_hit_q;
    assign head_col   = head_col_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_snake_row_scheduler.sv
// tb/tb_snake_row_scheduler.sv - self-checking bench for snake_row_scheduler
module tb_snake_row_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        row_req;
    logic [31:0] row_idx;
    logic [7:0]  seg_count;
    logic        seg_rd;
    logic [6:0]  seg_addr;
    logic [31:0] seg_x;
    logic [31:0] seg_y;
    logic        busy;
    logic [9:0]  row_mask;
    logic        head_hit;
    logic [3:0]  head_col;
    logic        mask_valid;
    logic        overrun;

    logic [31:0] ram_x [128];
    logic [31:0] ram_y [128];

    int total = 0;
    int bad   = 0;
    logic ovr_exp = 1'b0;

    snake_row_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .row_req     (row_req),
        .row_idx     (row_idx),
        .seg_count   (seg_count),
        .seg_rd      (seg_rd),
        .seg_addr    (seg_addr),
        .seg_x       (seg_x),
        .seg_y       (seg_y),
        .busy        (busy),
        .row_mask    (row_mask),
        .head_hit    (head_hit),
        .head_col    (head_col),
        .mask_valid  (mask_valid),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (seg_rd) begin
            seg_x <= ram_x[seg_addr];
            seg_y <= ram_y[seg_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [31:0] row, input int cnt,
                                  output logic [9:0] m, output logic hh, output logic [3:0] hc,
                                  output int e, output int reads);
        int n;
        n = (cnt > 100) ? 100 : cnt;
        m = '0; hh = 1'b0; hc = '0; e = n; reads = n;
        for (int i = 0; i < n; i++) begin
            if (ram_x[i] == 32'hFFFF_FFFF || ram_y[i] == 32'hFFFF_FFFF) begin
                e = i + 1;
                reads = (i + 1 < n) ? i + 2 : n;
                break;
            end
            if (ram_y[i] == row && row < 10 && ram_x[i] < 10) begin
                m[ram_x[i]] = 1'b1;
                if (i == 0) begin
                    hh = 1'b1;
                    hc = ram_x[i][3:0];
                end
            end
        end
    endfunction

    task automatic set_seg(input int i, input logic [31:0] x, input logic [31:0] y);
        ram_x[i] = x;
        ram_y[i] = y;
    endtask

    task automatic run_scan(input string tag, input logic [31:0] row, input int cnt, input int poke);
        logic [9:0] em;
        logic       ehh;
        logic [3:0] ehc;
        int         ee, ereads, lat, nreads;
        bit         addr_ok, busy1, busy_mv;
        model(row, cnt, em, ehh, ehc, ee, ereads);
        row_idx   = row;
        seg_count = 8'(cnt);
        row_req   = 1'b1;
        lat = -1; nreads = 0; addr_ok = 1'b1; busy1 = 1'b0; busy_mv = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 1) busy1 = busy;
            if (seg_rd) begin
                if (seg_addr != 7'(nreads)) addr_ok = 1'b0;
                nreads++;
            end
            if (mask_valid) begin
                lat = c;
                busy_mv = busy;
                break;
            end
            row_req = (c == poke);
        end
        row_req = 1'b0;
        if (poke > 0 && poke < lat) ovr_exp = 1'b1;
        check({tag, "_latency"}, 32'(lat), 32'(ee + 2));
        check({tag, "_mask"}, 32'(row_mask), 32'(em));
        check({tag, "_head_hit"}, 32'(head_hit), 32'(ehh));
        if (ehh) check({tag, "_head_col"}, 32'(head_col), 32'(ehc));
        check({tag, "_reads"}, 32'(nreads), 32'(ereads));
        check({tag, "_addr_seq"}, 32'(addr_ok), 32'd1);
        check({tag, "_busy_c1"}, 32'(busy1), 32'd1);
        check({tag, "_busy_mv"}, 32'(busy_mv), 32'd1);
        check({tag, "_overrun"}, 32'(overrun), 32'(ovr_exp));
        @(negedge clk);
        check({tag, "_mv_pulse"}, 32'(mask_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int mv_seen;
        reset = 1'b0; frame_start = 1'b0; row_req = 1'b0; row_idx = '0; seg_count = '0;
        seg_x = '0; seg_y = '0;
        for (int i = 0; i < 128; i++) set_seg(i, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        check("rst_outputs", {20'd0, busy, row_mask, head_hit, head_col, mask_valid, overrun, seg_rd}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        set_seg(0, 3, 2); set_seg(1, 4, 2); set_seg(2, 4, 3);
        run_scan("t1", 2, 3, 0);
        check("t1_mask_const", 32'(row_mask), 32'b0000011000);
        check("t1_head_col_const", 32'(head_col), 32'd3);
        run_scan("t2", 3, 3, 0);
        check("t2_mask_const", 32'(row_mask), 32'b0000010000);

        set_seg(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF); set_seg(3, 5, 2); set_seg(4, 6, 2);
        run_scan("t3_term", 2, 5, 0);
        run_scan("t4_empty", 2, 0, 0);
        run_scan("t4_bigrow", 32'd12, 3, 0);

        for (int i = 0; i < 10; i++) set_seg(i, 32'(i), 32'(i % 3));
        run_scan("t5_overrun", 1, 10, 2);
        check("t5_overrun_set", 32'(overrun), 32'd1);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        ovr_exp = 1'b0;
        check("t5_fs_overrun", 32'(overrun), 32'd0);
        check("t5_fs_mask", 32'(row_mask), 32'd0);
        check("t5_fs_head", 32'(head_hit), 32'd0);

        run_scan("t6_prefill", 1, 10, 0);
        row_idx = 0; seg_count = 8'd10; row_req = 1'b1;
        @(negedge clk);
        row_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t6_rst_outputs", {20'd0, busy, row_mask, head_hit, head_col, mask_valid, overrun, seg_rd}, 32'd0);
        mv_seen = 0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (mask_valid) mv_seen++;
        end
        check("t6_no_mask_valid", 32'(mv_seen), 32'd0);
        check("t6_idle", 32'(busy), 32'd0);
        set_seg(0, 9, 0);
        run_scan("t6_after", 0, 1, 0);
        check("t6_mask_const", 32'(row_mask), 32'b1000000000);

        for (int it = 0; it < 25; it++) begin
            int cnt;
            bit cap;
            cap = (it % 8 == 7);
            for (int i = 0; i < 128; i++) begin
                if (!cap && $urandom_range(0, 11) == 0) set_seg(i, 32'hFFFF_FFFF, $urandom_range(0, 9));
                else set_seg(i, $urandom_range(0, 12), $urandom_range(0, 11));
            end
            cnt = cap ? 110 : $urandom_range(0, 14);
            run_scan($sformatf("rnd%0d", it), $urandom_range(0, 11), cnt, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
